adbg_status_evq: RTL

- Single-clock consumer for a 4-bit debug status word that has already been synchronized into the local domain, e.g. the DATA_OUT of the status sync register.
- Watches the word for changes on enabled bits and queues each change as an event {previous, new} in a small show-ahead FIFO.
- Presents queued events to the debug module's reader through a valid/ready handshake and flags lost events.

---
 rtl/adbg_evq_pkg.sv | 17 +
 rtl/adbg_evq_fifo.sv | 72 +++++++
 rtl/adbg_status_evq.sv | 100 ++++++++++
 3 files changed

// File: rtl/adbg_evq_pkg.sv
// Shared types and helpers for the debug status event queue.
// Used by adbg_evq_fifo and adbg_status_evq.
package adbg_evq_pkg;

  localparam int STAT_W = 4;

  typedef struct packed {
    logic [STAT_W-1:0] prev;
    logic [STAT_W-1:0] curr;
  } evt_word_t;

  // Pointer width: one extra MSB beyond the index separates full from empty.
  function automatic int evq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adbg_evq_fifo.sv
// Generic single-clock show-ahead FIFO with registered head data and
// registered occupancy count.
module adbg_evq_fifo
  import adbg_evq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [evq_ptr_w(DEPTH)-1:0]  count
);

  localparam int PW = evq_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = wr_ptr_d - rd_ptr_d;
    dout_d   = dout_q;
    // The head register holds its last value once the FIFO drains.
    if (wr_ptr_d != rd_ptr_d) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) dout_d = din;
      else                                   dout_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // NOTE: storage is not reset; pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/adbg_status_evq.sv
// Debug status change-event queue: detects masked changes on a synchronized
// status word and queues {prev, new} events. Optional timestamps: ADBG_EVQ_TIMESTAMP_EN.
module adbg_status_evq
  import adbg_evq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 8
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [STAT_W-1:0]                   DATA_IN,
  input  logic [STAT_W-1:0]                   EDGE_MASK,
  output logic                                EVT_VALID,
  input  logic                                EVT_READY,
`ifdef ADBG_EVQ_TIMESTAMP_EN
  output logic [2*STAT_W+TS_WIDTH-1:0]        EVT_DATA,
`else
  output logic [2*STAT_W-1:0]                 EVT_DATA,
`endif
  output logic [evq_ptr_w(DEPTH)-1:0]         COUNT,
  output logic                                OVERFLOW,
  input  logic                                CLR_OVF
);

`ifdef ADBG_EVQ_TIMESTAMP_EN
  localparam int DW = 2 * STAT_W + TS_WIDTH;
`else
  localparam int DW = 2 * STAT_W;
`endif

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TS_WIDTH < 1)) begin : g_bad_cfg
    $error("adbg_status_evq: DEPTH must be a power of 2 >= 2 and TS_WIDTH >= 1");
  end

  logic [STAT_W-1:0] prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic              evt, pop, fifo_full, fifo_empty;
  evt_word_t         word;
  logic [DW-1:0]     push_data;

  assign evt  = |((DATA_IN ^ prev_q) & EDGE_MASK);
  assign pop  = ~fifo_empty & EVT_READY;

  always_comb begin
    word.prev = prev_q;
    word.curr = DATA_IN;
    prev_d    = DATA_IN;
    ovf_d     = ovf_q;
    if (CLR_OVF) ovf_d = 1'b0;
    // A drop on the clearing edge still leaves OVERFLOW set.
    if (evt && fifo_full && !pop) ovf_d = 1'b1;
  end

`ifdef ADBG_EVQ_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  always_comb begin
    ts_d      = ts_q + TS_WIDTH'(1);
    push_data = {ts_q, word};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`else
  always_comb begin
    push_data = word;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
    end
  end

  adbg_evq_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (evt),
    .pop   (pop),
    .din   (push_data),
    .dout  (EVT_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (COUNT)
  );

  assign EVT_VALID = ~fifo_empty;
  assign OVERFLOW  = ovf_q;

endmodule
